// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku puzzle generator blocks.
// Provides board geometry, the blank-picker FSM state encoding and the
// row/column to flat cell index mapping.
package sudoku_pkg;

  localparam int BOARD_N = 9;
  localparam int CELLS   = BOARD_N * BOARD_N;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    EMIT,
    DONE
  } state_t;

  typedef logic [6:0] cell_idx_t;

  // Flat index row*9+col; callers guarantee row and col are in 0..8.
  function automatic cell_idx_t cell_idx(input logic [3:0] row, input logic [3:0] col);
    return 7'(row) * 7'(BOARD_N) + 7'(col);
  endfunction

endpackage

// File: rtl/blank_mask.sv
// 81-bit record of cells already blanked in the current puzzle.
// clear wipes the record, set_en marks set_idx, test_hit reports whether
// test_idx is taken. With SYMMETRIC=1 a cell also counts as taken when its
// point-mirror (8-r,8-c) is taken.
module blank_mask
  import sudoku_pkg::*;
#(
  parameter bit SYMMETRIC = 1'b0
) (
  input  logic      clka,
  input  logic      restart_n,
  input  logic      clear,
  input  logic      set_en,
  input  cell_idx_t set_idx,
  input  cell_idx_t test_idx,
  output logic      test_hit
);

  logic [CELLS-1:0] mask;

  // Point mirror through the board centre: (8-r)*9+(8-c) == 80-(r*9+c).
  function automatic cell_idx_t mirror_idx(input cell_idx_t idx);
    return cell_idx_t'(CELLS - 1) - idx;
  endfunction

  // Mask storage: cleared on reset and at the start of each run, bits set one at a time.
  // NOTE: this register bank is reset because a fresh run must never see stale
  // blanks; a plain data RAM would normally be left unreset.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      mask <= '0;
    end else if (clear) begin
      mask <= '0;
    end else if (set_en) begin
      mask[set_idx] <= 1'b1;
    end
  end

  assign test_hit = mask[test_idx] | (SYMMETRIC & mask[mirror_idx(test_idx)]);

endmodule

// File: rtl/sudoku_blank_picker.sv
// Picks the distinct cells blanked from a solved board to form the puzzle.
// Requests RNG nibbles, rejection-samples (row,col) candidates, and issues one
// clear-cell write per accepted cell over a valid/ready port.
// Optional feature: define SYMMETRIC_BLANK_EN to blank cells in point-mirrored
// pairs (the centre cell is blanked alone).
module sudoku_blank_picker
  import sudoku_pkg::*;
#(
  parameter int N           = BOARD_N,
  parameter int BASE_BLANKS = 40,
  parameter int RNG_LAT     = 2,
  parameter int MAX_TRIES   = 255
) (
  input  logic       clka,
  input  logic       restart_n,
  input  logic       start,
  input  logic [3:0] rand_setup,
  input  logic [3:0] rand_A,
  input  logic [3:0] rand_B,
  output logic       gen_rand_flag,
  output logic       clr_valid,
  input  logic       clr_ready,
  output logic [3:0] clr_row,
  output logic [3:0] clr_col,
  output logic       busy,
  output logic       done,
  output logic [6:0] blank_count,
  output logic       stall_err
);

`ifdef SYMMETRIC_BLANK_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  localparam logic [3:0] CENTRE = 4'((N - 1) / 2);

  state_t     state;
  logic [6:0] target;
  logic [7:0] tries;
  logic [7:0] wait_cnt;
  logic       mirror_pending;  // second half of a symmetric pair still to emit

  logic       in_range;
  logic       cand_hit;
  logic       cand_free;
  cell_idx_t  cand_idx;
  cell_idx_t  emit_idx;
  logic [6:0] count_inc;
  logic       mask_clear;
  logic       mask_set;

  // Out-of-range candidates are steered to index 0 so they never address the mask.
  assign in_range   = (rand_A < 4'(N)) && (rand_B < 4'(N));
  assign cand_idx   = in_range ? cell_idx(rand_A, rand_B) : '0;
  assign cand_free  = in_range && !cand_hit;
  assign emit_idx   = cell_idx(clr_row, clr_col);
  assign count_inc  = blank_count + 7'd1;
  assign mask_clear = (state == IDLE) && start;
  assign mask_set   = (state == EMIT) && clr_ready;

  blank_mask #(
    .SYMMETRIC (SYM)
  ) u_mask (
    .clka      (clka),
    .restart_n (restart_n),
    .clear     (mask_clear),
    .set_en    (mask_set),
    .set_idx   (emit_idx),
    .test_idx  (cand_idx),
    .test_hit  (cand_hit)
  );

  // Picker FSM with registered outputs, try counter and target latch.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clka) begin
    if (!restart_n) begin
      state          <= IDLE;
      target         <= '0;
      tries          <= '0;
      wait_cnt       <= '0;
      mirror_pending <= 1'b0;
      gen_rand_flag  <= 1'b0;
      clr_valid      <= 1'b0;
      clr_row        <= '0;
      clr_col        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      blank_count    <= '0;
      stall_err      <= 1'b0;
    end else begin
      gen_rand_flag <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target        <= 7'(BASE_BLANKS) + 7'(rand_setup);
            blank_count   <= '0;
            tries         <= '0;
            stall_err     <= 1'b0;
            busy          <= 1'b1;
            gen_rand_flag <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 8'(RNG_LAT - 1)) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        CHECK: begin
          if (!cand_free) begin
            tries <= tries + 8'd1;
            if (tries == 8'(MAX_TRIES - 1)) begin
              stall_err <= 1'b1;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              gen_rand_flag <= 1'b1;
              state         <= REQ;
            end
          end else begin
            tries          <= '0;
            clr_row        <= rand_A;
            clr_col        <= rand_B;
            clr_valid      <= 1'b1;
            mirror_pending <= SYM && !((rand_A == CENTRE) && (rand_B == CENTRE));
            state          <= EMIT;
          end
        end
        EMIT: begin
          if (clr_ready) begin
            blank_count <= count_inc;
            if (mirror_pending) begin
              // Keep clr_valid high and present the mirror cell next cycle.
              mirror_pending <= 1'b0;
              clr_row        <= 4'(N - 1) - clr_row;
              clr_col        <= 4'(N - 1) - clr_col;
            end else begin
              clr_valid <= 1'b0;
              if (count_inc >= target) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                gen_rand_flag <= 1'b1;
                state         <= REQ;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_blank_picker.sv
// Self-checking bench for sudoku_blank_picker. An RNG stand-in feeds scripted or
// shuffled candidates on each gen_rand_flag; a reference model replays the
// blanking rules over the same candidate list to predict the clears.
module tb_sudoku_blank_picker;

`ifdef SYMMETRIC_BLANK_EN
  localparam bit SYM = 1'b1;
`else
  localparam bit SYM = 1'b0;
`endif

  logic       clka = 1'b0;
  logic       restart_n;
  logic       start;
  logic [3:0] rand_setup;
  logic [3:0] rand_A;
  logic [3:0] rand_B;
  logic       gen_rand_flag;
  logic       clr_valid;
  logic       clr_ready;
  logic [3:0] clr_row;
  logic [3:0] clr_col;
  logic       busy;
  logic       done;
  logic [6:0] blank_count;
  logic       stall_err;

  int vectors     = 0;
  int miscompares = 0;
  int gen_cnt     = 0;
  int done_cnt    = 0;

  logic [7:0] cand_q[$];  // candidates handed out on gen_rand_flag, {row,col}
  logic [7:0] hs_q[$];    // observed clear handshakes, {row,col}
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];

  sudoku_blank_picker dut (
    .clka          (clka),
    .restart_n     (restart_n),
    .start         (start),
    .rand_setup    (rand_setup),
    .rand_A        (rand_A),
    .rand_B        (rand_B),
    .gen_rand_flag (gen_rand_flag),
    .clr_valid     (clr_valid),
    .clr_ready     (clr_ready),
    .clr_row       (clr_row),
    .clr_col       (clr_col),
    .busy          (busy),
    .done          (done),
    .blank_count   (blank_count),
    .stall_err     (stall_err)
  );

  always #5 clka = ~clka;

  // RNG stand-in and bus monitor, sampled away from the rising edge.
  always @(negedge clka) begin
    logic [7:0] c;
    if (gen_rand_flag === 1'b1) begin
      gen_cnt++;
      c = (cand_q.size() > 0) ? cand_q.pop_front() : 8'hFF;
      rand_A = c[7:4];
      rand_B = c[3:0];
    end
    if (clr_valid === 1'b1 && clr_ready === 1'b1) hs_q.push_back({clr_row, clr_col});
    if (done === 1'b1) done_cnt++;
  end

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle_in();
    @(posedge clka);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] setup);
    cycle_in();
    rand_setup = setup;
    start      = 1'b1;
    cycle_in();
    start      = 1'b0;
  endtask

  task automatic apply_reset();
    cycle_in();
    restart_n = 1'b0;
    cycle_in();
    restart_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    @(negedge clka);
    while (done !== 1'b1 && n < budget) begin
      @(negedge clka);
      n++;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: no done pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n = 0;
    @(negedge clka);
    while (clr_valid !== 1'b1 && n < budget) begin
      @(negedge clka);
      n++;
    end
    vectors++;
    if (clr_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: clr_valid not seen within %0d cycles", name, budget);
    end
  endtask

  // Reference model: walk the candidate list applying the blanking rules.
  task automatic model_run(input int target, output int used);
    bit taken[9][9];
    int cnt = 0;
    int r, c, mr, mc;
    used = 0;
    exp_q.delete();
    foreach (taken[i, j]) taken[i][j] = 1'b0;
    foreach (stim_q[i]) begin
      if (cnt >= target) break;
      used++;
      r = int'(stim_q[i][7:4]);
      c = int'(stim_q[i][3:0]);
      if (r <= 8 && c <= 8) begin
        mr = 8 - r;
        mc = 8 - c;
        if (!taken[r][c] && (!SYM || !taken[mr][mc])) begin
          taken[r][c] = 1'b1;
          exp_q.push_back(stim_q[i]);
          cnt++;
          if (SYM && !(r == 4 && c == 4)) begin
            taken[mr][mc] = 1'b1;
            exp_q.push_back({4'(mr), 4'(mc)});
            cnt++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    restart_n  = 1'b0;
    start      = 1'b1;
    clr_ready  = 1'b1;
    rand_setup = 4'd0;
    rand_A     = 4'd0;
    rand_B     = 4'd0;
    repeat (2) @(posedge clka);
    @(negedge clka);
    check_val("reset gen_rand_flag", int'(gen_rand_flag), 0);
    check_val("reset clr_valid", int'(clr_valid), 0);
    check_val("reset clr_row", int'(clr_row), 0);
    check_val("reset clr_col", int'(clr_col), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset done", int'(done), 0);
    check_val("reset blank_count", int'(blank_count), 0);
    check_val("reset stall_err", int'(stall_err), 0);
    #1;
    start     = 1'b0;
    restart_n = 1'b1;
    repeat (3) @(negedge clka);
    check_val("idle busy", int'(busy), 0);
    check_val("idle gen pulses", gen_cnt, 0);
  endtask

  task automatic test_random_run(input logic [3:0] setup);
    int perm[81];
    int used, j, tmp;
    stim_q.delete();
    for (int i = 0; i < 81; i++) perm[i] = i;
    for (int i = 80; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 81; i++) begin
      if ($urandom_range(0, 3) == 0)
        stim_q.push_back({4'($urandom_range(9, 15)), 4'($urandom_range(0, 15))});
      if ($urandom_range(0, 5) == 0)
        stim_q.push_back({4'($urandom_range(0, 8)), 4'($urandom_range(9, 15))});
      stim_q.push_back({4'(perm[i] / 9), 4'(perm[i] % 9)});
    end
    model_run(40 + int'(setup), used);
    cand_q = stim_q;
    hs_q.delete();
    gen_cnt   = 0;
    clr_ready = 1'b1;
    pulse_start(setup);
    check_val("run busy after start", int'(busy), 1);
    wait_done(5000, "run done");
    check_val("run blank_count", int'(blank_count), exp_q.size());
    check_val("run busy at done", int'(busy), 0);
    check_val("run stall_err", int'(stall_err), 0);
    check_val("run gen pulses", gen_cnt, used);
    check_val("run clear count", hs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
      check_val($sformatf("run clear %0d", i), int'(hs_q[i]), int'(exp_q[i]));
    cand_q.delete();
  endtask

  task automatic test_rejects();
    cand_q.delete();
    cand_q.push_back({4'd12, 4'd2});
    cand_q.push_back({4'd5, 4'd15});
    cand_q.push_back({4'd5, 4'd2});
    gen_cnt   = 0;
    clr_ready = 1'b1;
    pulse_start(4'd0);
    wait_valid(100, "reject first valid");
    check_val("reject gen pulses", gen_cnt, 3);
    check_val("reject clr_row", int'(clr_row), 5);
    check_val("reject clr_col", int'(clr_col), 2);
    apply_reset();
  endtask

  task automatic test_stall();
    cand_q.delete();
    hs_q.delete();
    for (int i = 0; i < 255; i++) cand_q.push_back({4'd3, 4'd3});
    cand_q.push_back({4'd0, 4'd0});
    for (int i = 0; i < 255; i++) cand_q.push_back({4'd3, 4'd3});
    gen_cnt   = 0;
    clr_ready = 1'b1;
    pulse_start(4'd7);
    wait_done(6000, "stall done");
    check_val("stall stall_err", int'(stall_err), 1);
    check_val("stall busy", int'(busy), 0);
    check_val("stall blank_count", int'(blank_count), 2);
    check_val("stall gen pulses", gen_cnt, 511);
    check_val("stall clear count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      check_val("stall clear 0", int'(hs_q[0]), 8'h33);
      check_val("stall clear 1", int'(hs_q[1]), 8'h00);
    end
    cand_q.delete();
  endtask

  task automatic test_backpressure();
    cand_q.delete();
    cand_q.push_back({4'd6, 4'd7});
    clr_ready = 1'b0;
    pulse_start(4'd1);
    check_val("bp stall_err cleared", int'(stall_err), 0);
    wait_valid(100, "bp valid");
    for (int i = 0; i < 10; i++) begin
      check_val("bp clr_valid held", int'(clr_valid), 1);
      check_val("bp clr_row held", int'(clr_row), 6);
      check_val("bp clr_col held", int'(clr_col), 7);
      check_val("bp count held", int'(blank_count), 0);
      @(negedge clka);
    end
    cycle_in();
    clr_ready = 1'b1;
    @(posedge clka);
    @(negedge clka);
    check_val("bp count after handshake", int'(blank_count), 1);
    apply_reset();
  endtask

  task automatic test_reset_mid_emit();
    int d0;
    cand_q.delete();
    cand_q.push_back({4'd2, 4'd2});
    clr_ready = 1'b0;
    pulse_start(4'd2);
    wait_valid(100, "mid valid");
    d0 = done_cnt;
    apply_reset();
    @(negedge clka);
    check_val("mid clr_valid dropped", int'(clr_valid), 0);
    check_val("mid busy", int'(busy), 0);
    check_val("mid blank_count", int'(blank_count), 0);
    repeat (3) @(negedge clka);
    check_val("mid no done", done_cnt, d0);
    check_val("mid stays idle", int'(gen_rand_flag), 0);
    clr_ready = 1'b1;
  endtask

`ifdef SYMMETRIC_BLANK_EN
  task automatic test_symmetric();
    int n = 0;
    cand_q.delete();
    hs_q.delete();
    cand_q.push_back({4'd1, 4'd2});
    cand_q.push_back({4'd4, 4'd4});
    clr_ready = 1'b1;
    pulse_start(4'd0);
    while (hs_q.size() < 3 && n < 200) begin
      @(negedge clka);
      n++;
    end
    check_val("sym clear count", hs_q.size(), 3);
    if (hs_q.size() >= 3) begin
      check_val("sym clear 0", int'(hs_q[0]), 8'h12);
      check_val("sym clear 1", int'(hs_q[1]), 8'h76);
      check_val("sym clear 2", int'(hs_q[2]), 8'h44);
    end
    check_val("sym blank_count", int'(blank_count), 3);
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_random_run(4'd3);
    test_random_run(4'($urandom_range(0, 15)));
    test_random_run(4'd15);
    test_rejects();
    test_stall();
    test_backpressure();
    test_reset_mid_emit();
`ifdef SYMMETRIC_BLANK_EN
    test_symmetric();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
